// File: rtl/soc_bram_copy.sv
// soc_bram_copy: word-granular copy/fill engine driving one single-port block
// RAM port (1-cycle registered read, active-low byte write mask).
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_src/dst/len   command: source, destination, length in words (0..2^AW)
//   cmd_fill          1 = fill dst with cmd_pattern, 0 = copy src -> dst
//   cmd_pattern       fill word
//   cmd_valid/ready   command handshake; ready in IDLE and DONE
//   busy              command in progress (RD/WR/FILL)
//   done              one-cycle completion pulse
//   mem_addr/we/wmsk  RAM address, write enable, active-low byte mask
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data, valid the cycle after its address
module soc_bram_copy #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] cmd_src,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW:0]   cmd_len,
   input  logic          cmd_fill,
   input  logic [31:0]   cmd_pattern,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wmsk,
   output logic          mem_we
);

   typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

   state_t        state_q;
   logic [AW-1:0] src_q, dst_q, addr_q;
   logic [AW:0]   len_q;
   logic [31:0]   pat_q;
   logic          we_q, busy_q, done_q, rdy_q;
   logic [3:0]    wmsk_q;

   logic accept, last;
   assign accept = cmd_valid & rdy_q;
   // len_q counts words still to write, so 1 means this write is the final one
   assign last   = (len_q == (AW+1)'(1));

   // Outputs are registered: each transition preloads the RAM controls the
   // next state presents, so every state drives its access from its first cycle.
   // The fill/copy choice is carried by the state itself, so no mode register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         pat_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wmsk_q  <= 4'hF;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            // DONE accepts exactly like IDLE so back-to-back commands lose no cycle
            IDLE, DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               rdy_q   <= 1'b1;
               busy_q  <= 1'b0;
               we_q    <= 1'b0;
               wmsk_q  <= 4'hF;
               if (accept) begin
                  src_q <= cmd_src;
                  dst_q <= cmd_dst;
                  len_q <= cmd_len;
                  pat_q <= cmd_pattern;
                  if (cmd_len == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (cmd_fill) begin
                     state_q <= FILL;
                     addr_q  <= cmd_dst;
                     we_q    <= 1'b1;
                     wmsk_q  <= 4'h0;
                     busy_q  <= 1'b1;
                     rdy_q   <= 1'b0;
                  end else begin
                     state_q <= RD;
                     addr_q  <= cmd_src;
                     busy_q  <= 1'b1;
                     rdy_q   <= 1'b0;
                  end
               end
            end
            RD: begin
               src_q   <= src_q + AW'(1);
               state_q <= WR;
               addr_q  <= dst_q;
               we_q    <= 1'b1;
               wmsk_q  <= 4'h0;
            end
            WR, FILL: begin
               dst_q <= dst_q + AW'(1);
               len_q <= len_q - (AW+1)'(1);
               if (last) begin
                  // mem_addr keeps the final write address
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  we_q    <= 1'b0;
                  wmsk_q  <= 4'hF;
               end else if (state_q == FILL) begin
                  addr_q <= dst_q + AW'(1);
               end else begin
                  // src_q was already advanced in RD
                  state_q <= RD;
                  addr_q  <= src_q;
                  we_q    <= 1'b0;
                  wmsk_q  <= 4'hF;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Copy data is the word read last cycle, passed straight through to the write.
   always_comb begin
      mem_wdata = 32'h0;
      if (state_q == WR)        mem_wdata = mem_rdata;
      else if (state_q == FILL) mem_wdata = pat_q;
   end

   assign mem_addr  = addr_q;
   assign mem_we    = we_q;
   assign mem_wmsk  = wmsk_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_ready = rdy_q;

endmodule

// File: tb/tb_soc_bram_copy.sv
// Bench for soc_bram_copy: bench-owned RAM, a per-cycle expectation table built
// from the command schedule, and hand-computed literal checks.
module tb_soc_bram_copy;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cmd_src, cmd_dst;
   logic [8:0]  cmd_len;
   logic        cmd_fill, cmd_valid, cmd_ready, busy, done, mem_we;
   logic [31:0] cmd_pattern, mem_rdata, mem_wdata;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_wmsk;

   always #5 clk = ~clk;

   soc_bram_copy #(.AW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .cmd_fill(cmd_fill), .cmd_pattern(cmd_pattern), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
      .mem_wmsk(mem_wmsk), .mem_we(mem_we)
   );

   // RAM: registered read, active-low byte mask, plus a bench preload port
   logic [31:0] ram [256];
   logic        clr, pre_we;
   logic [7:0]  pre_a;
   logic [31:0] pre_d;
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= {4{8'(i)}};
      end else begin
         if (pre_we) ram[pre_a] <= pre_d;
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (!mem_wmsk[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit we, busy, dn, rdy, ca;
      logic [7:0]  addr;
      logic [31:0] wd;
   } exp_t;

   exp_t        ex [int];
   logic [31:0] mm [256];
   int checks = 0, errors = 0, last_done = -1;
   bit chk_en = 0;

   function automatic exp_t mk(bit we, bit bs, bit dn, bit rdy, bit ca,
                               logic [7:0] a, logic [31:0] d);
      exp_t e;
      e.we = we; e.busy = bs; e.dn = dn; e.rdy = rdy; e.ca = ca; e.addr = a; e.wd = d;
      return e;
   endfunction

   // Cycle-by-cycle comparison against the expectation table
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         e = ex.exists(cyc) ? ex[cyc] : mk(0, 0, 0, 1, 0, 8'h0, 32'h0);
         checks++;
         if (mem_we !== e.we || busy !== e.busy || done !== e.dn || cmd_ready !== e.rdy ||
             mem_wmsk !== (e.we ? 4'h0 : 4'hF) || mem_wdata !== (e.we ? e.wd : 32'h0) ||
             (e.ca && mem_addr !== e.addr)) begin
            errors++;
            $display("FAIL cycle %0d: got we=%b busy=%b done=%b rdy=%b msk=%h addr=%h wd=%h, want we=%b busy=%b done=%b rdy=%b addr=%h wd=%h",
                     cyc, mem_we, busy, done, cmd_ready, mem_wmsk, mem_addr, mem_wdata,
                     e.we, e.busy, e.dn, e.rdy, e.addr, e.wd);
         end
         if (e.we) mm[e.addr] = e.wd;
         if (done) last_done = cyc;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      pre_a = a; pre_d = d; pre_we = 1'b1; mm[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Present a command at a negedge; c0 is the cyc value of cycle 0 (accept edge
   // closes it). Expected schedule: copy reads on odd, writes on even cycles,
   // fill writes on 1..N, done one cycle after the last access.
   task automatic issue(input logic [7:0] s, input logic [7:0] d, input int n,
                        input bit f, input logic [31:0] p, output int c0);
      logic [31:0] tmp [256];
      logic [7:0]  a, b;
      c0 = cyc;
      cmd_src = s; cmd_dst = d; cmd_len = 9'(n); cmd_fill = f; cmd_pattern = p;
      cmd_valid = 1'b1;
      if (n == 0) begin
         ex[c0+1] = mk(0, 0, 1, 1, 0, 8'h0, 32'h0);
      end else if (f) begin
         for (int k = 0; k < n; k++) ex[c0+1+k] = mk(1, 1, 0, 0, 1, 8'(d+k), p);
         ex[c0+n+1] = mk(0, 0, 1, 1, 1, 8'(d+n-1), 32'h0);
      end else begin
         tmp = mm;
         for (int k = 0; k < n; k++) begin
            a = 8'(s+k); b = 8'(d+k);
            ex[c0+1+2*k] = mk(0, 1, 0, 0, 1, a, 32'h0);
            ex[c0+2+2*k] = mk(1, 1, 0, 0, 1, b, tmp[a]);
            tmp[b] = tmp[a];
         end
         ex[c0+2*n+1] = mk(0, 0, 1, 1, 1, 8'(d+n-1), 32'h0);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, c1, bad;
      for (int i = 0; i < 256; i++) mm[i] = {4{8'(i)}};
      rst_n = 1'b0; clr = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
      cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = 1'b0;
      cmd_pattern = '0; cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst busy", {31'b0, busy}, 32'h0);
      chk("rst done", {31'b0, done}, 32'h0);
      chk("rst ready", {31'b0, cmd_ready}, 32'h1);
      chk("rst we", {31'b0, mem_we}, 32'h0);
      chk("rst wmsk", {28'b0, mem_wmsk}, 32'hF);
      chk("rst addr", {24'b0, mem_addr}, 32'h0);
      chk("rst wdata", mem_wdata, 32'h0);
      clr = 1'b0; rst_n = 1'b1; chk_en = 1'b1;
      @(negedge clk);

      // Fill dst=0x10 len=4
      issue(8'h10, 8'h10, 4, 1, 32'hDEADBEEF, c0);
      repeat (8) @(negedge clk);
      chk("fill done cycle", 32'(last_done - c0), 32'd5);
      for (int i = 0; i < 4; i++) chk("fill word", ram[8'h10 + i], 32'hDEADBEEF);

      // Copy 0x00..0x02 -> 0x80
      preload(8'h00, 32'h11111111);
      preload(8'h01, 32'h22222222);
      preload(8'h02, 32'h33333333);
      issue(8'h00, 8'h80, 3, 0, 32'h0, c0);
      repeat (10) @(negedge clk);
      chk("copy done cycle", 32'(last_done - c0), 32'd7);
      chk("copy w80", ram[8'h80], 32'h11111111);
      chk("copy w81", ram[8'h81], 32'h22222222);
      chk("copy w82", ram[8'h82], 32'h33333333);

      // Wrap fill dst=0xFE len=4
      issue(8'h00, 8'hFE, 4, 1, 32'hCAFEF00D, c0);
      repeat (8) @(negedge clk);
      chk("wrap wFE", ram[8'hFE], 32'hCAFEF00D);
      chk("wrap wFF", ram[8'hFF], 32'hCAFEF00D);
      chk("wrap w00", ram[8'h00], 32'hCAFEF00D);
      chk("wrap w01", ram[8'h01], 32'hCAFEF00D);
      chk("wrap w02 untouched", ram[8'h02], 32'h33333333);
      chk("wrap wFD untouched", ram[8'hFD], 32'hFDFDFDFD);

      // len=0, then a fill presented during its DONE cycle
      issue(8'h00, 8'h40, 0, 0, 32'h0, c0);
      chk("len0 done pulse", {31'b0, done}, 32'h1);
      issue(8'h00, 8'h40, 2, 1, 32'h5A5A0F0F, c1);
      chk("b2b accept cycle", 32'(c1 - c0), 32'd1);
      chk("b2b first write", {31'b0, mem_we}, 32'h1);
      repeat (5) @(negedge clk);
      chk("b2b done cycle", 32'(last_done - c1), 32'd3);
      chk("b2b w41", ram[8'h41], 32'h5A5A0F0F);

      // Overlapped forward copy replicates the source word
      preload(8'h20, 32'hA5A5A5A5);
      issue(8'h20, 8'h21, 3, 0, 32'h0, c0);
      repeat (9) @(negedge clk);
      chk("ovl w21", ram[8'h21], 32'hA5A5A5A5);
      chk("ovl w22", ram[8'h22], 32'hA5A5A5A5);
      chk("ovl w23", ram[8'h23], 32'hA5A5A5A5);

      // Reset during cycle 3 of a len=8 copy
      issue(8'h30, 8'h90, 8, 0, 32'h0, c0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = c0 + 4; k <= c0 + 17; k++) if (ex.exists(k)) ex.delete(k);
      @(negedge clk);
      chk("abort busy", {31'b0, busy}, 32'h0);
      chk("abort ready", {31'b0, cmd_ready}, 32'h1);
      chk("abort we", {31'b0, mem_we}, 32'h0);
      chk("abort wmsk", {28'b0, mem_wmsk}, 32'hF);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort w90 written", ram[8'h90], 32'h30303030);
      chk("abort w91 untouched", ram[8'h91], 32'h91919191);
      chk("abort no done", (last_done > c0) ? 32'h1 : 32'h0, 32'h0);

      // Whole RAM against the model image
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== mm[i]) bad++;
      chk("ram image mismatches", 32'(bad), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/soc_bram_copy.md
# soc_bram_copy

Word-granular memory-to-memory engine that acts as the initiator on a single-port SoC block RAM port. The RAM has a 1-cycle registered read and an active-low byte write mask. The engine accepts a command (copy or fill), sequences the RAM address/data/strobe lines, and signals completion. It sits between a CPU-side register/command interface and one `soc_bram` instance, or one port of a RAM arbiter.

## Interface
Parameters:
- `AW`, 8: RAM word-address width. The RAM holds 2^AW 32-bit words.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `rst_n`  in  1: synchronous reset, active-low, sampled on `clk`.
- `cmd_src`  in  AW: copy source word address. Ignored in fill mode.
- `cmd_dst`  in  AW: destination word address.
- `cmd_len`  in  AW+1: length in words, 0 .. 2^AW.
- `cmd_fill`  in  1: 1 = fill destination with `cmd_pattern`; 0 = copy.
- `cmd_pattern`  in  32: fill word.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: engine idle. A command is accepted when `cmd_valid & cmd_ready`.
- `busy`  out  1: command in progress.
- `done`  out  1: one-cycle completion pulse.
- `mem_addr`  out  AW: RAM word address.
- `mem_rdata`  in  32: RAM read data, valid the cycle after its address.
- `mem_wdata`  out  32: RAM write data.
- `mem_wmsk`  out  4: byte mask, active-low. 0 = byte written.
- `mem_we`  out  1: RAM write enable.

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch src, dst, len, fill and pattern into internal registers; `cmd_*` inputs are don't-care afterwards.
  - Next state: DONE if len=0; else FILL if fill=1; else RD.
- RD:
  - `mem_addr`=src, `mem_we`=0.
  - src increments by 1. Next state: WR.
- WR:
  - `mem_addr`=dst, `mem_we`=1, `mem_wmsk`=4'h0, `mem_wdata`=`mem_rdata` (combinational pass-through of the word read in the previous cycle).
  - dst increments by 1; len decrements by 1.
  - Next state: DONE if len was 1; else RD.
- FILL:
  - `mem_addr`=dst, `mem_we`=1, `mem_wmsk`=4'h0, `mem_wdata`=pattern.
  - dst increments by 1; len decrements by 1.
  - Next state: DONE if len was 1; else FILL.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Outside WR/FILL: `mem_we`=0, `mem_wmsk`=4'hF, `mem_wdata`=0.
- Outside RD/WR/FILL: `mem_addr` holds its last value (0 after reset).
- `busy`=1 in RD, WR and FILL only. `cmd_ready`=1 in IDLE and DONE.
- Commands are accepted in DONE too. Acceptance in DONE behaves exactly like acceptance in IDLE, so back-to-back commands lose no cycle.
- Address arithmetic is modulo 2^AW; src and dst wrap from 2^AW-1 to 0 silently.
- `cmd_len`=2^AW (MSB set) is legal and covers the whole RAM once.
- Overlap: the copy runs strictly forward, word by word.
  - dst < src or no overlap: exact copy.
  - dst > src with overlap: the source pattern is replicated. This is defined behaviour, not an error.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State → IDLE.
  - `busy`=0, `done`=0, `cmd_ready`=1.
  - `mem_we`=0, `mem_wmsk`=4'hF, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-command aborts at once. The in-flight write completes only if its edge precedes reset; no further RAM access follows.
- Take the accept edge as cycle 0.
- Copy of N words:
  - Reads on cycles 1, 3, …, 2N-1; writes on cycles 2, 4, …, 2N.
  - `done` on cycle 2N+1.
  - Throughput is 2 cycles per word.
- Fill of N words: writes on cycles 1..N; `done` on cycle N+1.
- len=0: no RAM access; `busy` stays 0; `done` on cycle 1.
- `cmd_ready` falls on cycle 1 for N≥1. For len=0 it stays 1.

## Test plan
- Fill with dst=0x10, len=4, pattern=0xDEADBEEF:
  - `mem_we`=1 with addr 0x10..0x13 on cycles 1–4 and `mem_wmsk`=0.
  - `done` on cycle 5; RAM words 0x10–0x13 read 0xDEADBEEF.
- Copy after preloading words 0x00–0x02 with 0x11111111 / 0x22222222 / 0x33333333, src=0x00, dst=0x80, len=3:
  - Alternating RD/WR on cycles 1–6; `done` on cycle 7.
  - Words 0x80–0x82 match the source.
- Wrap with AW=8, fill dst=0xFE, len=4: writes to 0xFE, 0xFF, 0x00, 0x01, and no others.
- Zero length and back-to-back: a len=0 command gives `done` on cycle 1 with `mem_we` never high. A second fill is presented during the DONE cycle; it is accepted that cycle and its first write lands on the next cycle.
- Overlapped copy with word 0x20=0xA5A5A5A5, src=0x20, dst=0x21, len=3: words 0x21–0x23 all read 0xA5A5A5A5.
- Reset mid-copy, `rst_n`=0 on cycle 3 of a len=8 copy:
  - Next cycle: `busy`=0, `cmd_ready`=1, `mem_we`=0, `mem_wmsk`=4'hF.
  - No `done` pulse; only the cycle-2 write is observed.
